// File: rtl/cpu_pkg.sv
//------------------------------------------------------------------------------
// Module  : cpu_pkg
// Brief   : Shared CPU widths and types for the register file slice.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;
   localparam int XLEN       = 32;
   localparam int NUM_REGS   = 32;
   localparam int REG_ADDR_W = $clog2(NUM_REGS);

   typedef logic [XLEN-1:0]       xlen_t;
   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

`default_nettype wire

// File: rtl/wb_regfile_if.sv
//------------------------------------------------------------------------------
// Module  : wb_regfile_if
// Brief   : MEM/WB write-back, decode read ports and forwarding taps.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface wb_regfile_if
   import cpu_pkg::*;
#(
   parameter int XLEN = cpu_pkg::XLEN
);
   logic            RegWrite_i;
   logic            MemReg_i;
   reg_addr_t       rd_addr_i;
   logic [XLEN-1:0] data1_i;
   logic [XLEN-1:0] data2_i;
   reg_addr_t       rs1_addr_i;
   reg_addr_t       rs2_addr_i;
   logic [XLEN-1:0] rs1_data_o;
   logic [XLEN-1:0] rs2_data_o;
   logic [XLEN-1:0] wb_data_o;
   logic            wb_valid_o;
   logic [31:0]     retire_cnt_o;

   modport master (
      output RegWrite_i, MemReg_i, rd_addr_i, data1_i, data2_i,
             rs1_addr_i, rs2_addr_i,
      input  rs1_data_o, rs2_data_o, wb_data_o, wb_valid_o, retire_cnt_o
   );

   modport slave (
      input  RegWrite_i, MemReg_i, rd_addr_i, data1_i, data2_i,
             rs1_addr_i, rs2_addr_i,
      output rs1_data_o, rs2_data_o, wb_data_o, wb_valid_o, retire_cnt_o
   );
endinterface

`default_nettype wire

// File: rtl/wb_regfile_wb_select.sv
//------------------------------------------------------------------------------
// Module  : wb_select
// Brief   : Write-back value mux and write-valid qualification (x0 dropped).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wb_select
   import cpu_pkg::*;
#(
   parameter int XLEN = cpu_pkg::XLEN
) (
   input  logic            RegWrite_i,
   input  logic            MemReg_i,
   input  reg_addr_t       rd_addr_i,
   input  logic [XLEN-1:0] data1_i,
   input  logic [XLEN-1:0] data2_i,
   output logic [XLEN-1:0] wb_data_o,
   output logic            wb_valid_o
);
   assign wb_data_o  = MemReg_i ? data2_i : data1_i;
   assign wb_valid_o = RegWrite_i && (rd_addr_i != '0);
endmodule

`default_nettype wire

// File: rtl/wb_regfile.sv
//------------------------------------------------------------------------------
// Module  : wb_regfile
// Brief   : Write-back stage, 2R1W architectural register file, retire count.
//           Optional macro WB_BYPASS_EN enables same-cycle write-through reads.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wb_regfile
   import cpu_pkg::*;
#(
   parameter int XLEN     = cpu_pkg::XLEN,
   parameter int NUM_REGS = cpu_pkg::NUM_REGS
) (
   input  logic       clk_i,
   input  logic       rst_i,
   wb_regfile_if.slave bus
);
   logic [XLEN-1:0] regs_q [NUM_REGS];
   logic [31:0]     retire_cnt_q;
   logic [31:0]     retire_cnt_d;
   logic [XLEN-1:0] wb_data;
   logic            wb_valid;

   wb_select #(.XLEN(XLEN)) u_wb_select (
      .RegWrite_i (bus.RegWrite_i),
      .MemReg_i   (bus.MemReg_i),
      .rd_addr_i  (bus.rd_addr_i),
      .data1_i    (bus.data1_i),
      .data2_i    (bus.data2_i),
      .wb_data_o  (wb_data),
      .wb_valid_o (wb_valid)
   );

   function automatic logic [XLEN-1:0] read_port(input reg_addr_t addr);
      logic [XLEN-1:0] val;
      val = '0;
      if (addr != '0) begin
         val = regs_q[addr];
`ifdef WB_BYPASS_EN
         // Reset must hide the in-flight write, since it will never commit.
         if (!rst_i && wb_valid && (addr == bus.rd_addr_i))
            val = wb_data;
`endif
      end
      return val;
   endfunction

   always_comb begin
      retire_cnt_d = retire_cnt_q;
      if (wb_valid)
         retire_cnt_d = retire_cnt_q + 32'd1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_REGS; i++)
            regs_q[i] <= '0;
         retire_cnt_q <= '0;
      end else begin
         if (wb_valid)
            regs_q[bus.rd_addr_i] <= wb_data;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   assign bus.rs1_data_o   = read_port(bus.rs1_addr_i);
   assign bus.rs2_data_o   = read_port(bus.rs2_addr_i);
   assign bus.wb_data_o    = wb_data;
   assign bus.wb_valid_o   = wb_valid;
   assign bus.retire_cnt_o = retire_cnt_q;
endmodule

`default_nettype wire

// File: tb/tb_wb_regfile.sv
//------------------------------------------------------------------------------
// Module  : tb_wb_regfile
// Brief   : Self-checking bench for wb_regfile (vector table, corners, random).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_wb_regfile;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wb_regfile_if bus ();

   wb_regfile u_dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [31:0] model_regs [32];
   logic [31:0] model_cnt;

`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct {
      logic        we;
      logic        mr;
      logic [4:0]  rd;
      logic [31:0] d1;
      logic [31:0] d2;
      logic [4:0]  a1;
      logic [4:0]  a2;
      logic [31:0] exp_wbd;
      logic        exp_wbv;
      logic [31:0] exp_rs1_nb;
      logic [31:0] exp_rs1_byp;
      logic [31:0] exp_rs2_nb;
      logic [31:0] exp_rs2_byp;
      logic [31:0] exp_cnt;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic drive(input logic r, input logic we, input logic mr,
                        input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [4:0] a1, input logic [4:0] a2);
      @(negedge clk);
      rst             = r;
      bus.RegWrite_i  = we;
      bus.MemReg_i    = mr;
      bus.rd_addr_i   = rd;
      bus.data1_i     = d1;
      bus.data2_i     = d2;
      bus.rs1_addr_i  = a1;
      bus.rs2_addr_i  = a2;
      #1;
   endtask

   // Advance one edge and apply the architectural rule to the reference state.
   task automatic clock_edge();
      logic [31:0] wbd;
      wbd = bus.MemReg_i ? bus.data2_i : bus.data1_i;
      @(posedge clk);
      #1;
      if (rst) begin
         foreach (model_regs[i]) model_regs[i] = 32'h0;
         model_cnt = 32'h0;
      end else if (bus.RegWrite_i && bus.rd_addr_i != 5'd0) begin
         model_regs[bus.rd_addr_i] = wbd;
         model_cnt = model_cnt + 32'd1;
      end
   endtask

   function automatic logic [31:0] model_read(input logic [4:0] a);
      logic [31:0] wbd;
      wbd = bus.MemReg_i ? bus.data2_i : bus.data1_i;
      if (a == 5'd0) return 32'h0;
      if (BYP && !rst && bus.RegWrite_i && bus.rd_addr_i != 5'd0 && a == bus.rd_addr_i)
         return wbd;
      return model_regs[a];
   endfunction

   initial begin
      logic we, mr, r;
      logic [4:0] rd, a1, a2;
      logic [31:0] d1, d2;

      foreach (model_regs[i]) model_regs[i] = 32'hx;
      model_cnt = 32'hx;

      // Reset for two cycles
      drive(1'b1, 1'b1, 1'b0, 5'd3, 32'h1111, 32'h0, 5'd0, 5'd0);
      clock_edge();
      drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
      clock_edge();
      for (int i = 1; i < 32; i++) begin
         drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'(i), 5'(32 - i));
         check("reset_rs1", bus.rs1_data_o, 32'h0);
         check("reset_rs2", bus.rs2_data_o, 32'h0);
         clock_edge();
      end
      check("reset_cnt", bus.retire_cnt_o, 32'h0);

      // we mr rd d1 d2 a1 a2 | wbd wbv rs1(nb,byp) rs2(nb,byp) cnt_after
      vecs[0] = '{1'b1, 1'b0, 5'd5, 32'h12345678, 32'hDEADBEEF, 5'd5, 5'd6,
                  32'h12345678, 1'b1, 32'h0, 32'h12345678, 32'h0, 32'h0, 32'd1};
      vecs[1] = '{1'b1, 1'b1, 5'd6, 32'h00000000, 32'hDEADBEEF, 5'd5, 5'd6,
                  32'hDEADBEEF, 1'b1, 32'h12345678, 32'h12345678, 32'h0, 32'hDEADBEEF, 32'd2};
      vecs[2] = '{1'b1, 1'b0, 5'd0, 32'hFFFFFFFF, 32'h00000000, 5'd0, 5'd5,
                  32'hFFFFFFFF, 1'b0, 32'h0, 32'h0, 32'h12345678, 32'h12345678, 32'd2};
      vecs[3] = '{1'b0, 1'b1, 5'd6, 32'h00000001, 32'h00000002, 5'd6, 5'd0,
                  32'h00000002, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 32'h0, 32'd2};
      vecs[4] = '{1'b1, 1'b0, 5'd7, 32'h00000001, 32'h00000000, 5'd0, 5'd0,
                  32'h00000001, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 32'd3};
      vecs[5] = '{1'b1, 1'b0, 5'd7, 32'hA5A5A5A5, 32'h00000000, 5'd7, 5'd7,
                  32'hA5A5A5A5, 1'b1, 32'h1, 32'hA5A5A5A5, 32'h1, 32'hA5A5A5A5, 32'd4};
      vecs[6] = '{1'b0, 1'b0, 5'd0, 32'h00000000, 32'h00000000, 5'd7, 5'd7,
                  32'h00000000, 1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'd4};

      foreach (vecs[k]) begin
         drive(1'b0, vecs[k].we, vecs[k].mr, vecs[k].rd, vecs[k].d1, vecs[k].d2,
               vecs[k].a1, vecs[k].a2);
         check($sformatf("vec%0d_wbd", k), bus.wb_data_o, vecs[k].exp_wbd);
         check($sformatf("vec%0d_wbv", k), 32'(bus.wb_valid_o), 32'(vecs[k].exp_wbv));
         check($sformatf("vec%0d_rs1", k), bus.rs1_data_o,
               BYP ? vecs[k].exp_rs1_byp : vecs[k].exp_rs1_nb);
         check($sformatf("vec%0d_rs2", k), bus.rs2_data_o,
               BYP ? vecs[k].exp_rs2_byp : vecs[k].exp_rs2_nb);
         clock_edge();
         check($sformatf("vec%0d_cnt", k), bus.retire_cnt_o, vecs[k].exp_cnt);
      end

      // Reset colliding with a write: write lost, bypass suppressed
      drive(1'b0, 1'b1, 1'b0, 5'd9, 32'h99, 32'h0, 5'd0, 5'd0);
      clock_edge();
      drive(1'b1, 1'b1, 1'b0, 5'd9, 32'h55, 32'h0, 5'd9, 5'd7);
      check("rst_cycle_rs1", bus.rs1_data_o, 32'h99);
      check("rst_cycle_rs2", bus.rs2_data_o, 32'hA5A5A5A5);
      clock_edge();
      drive(1'b0, 1'b1, 1'b0, 5'd9, 32'h55, 32'h0, 5'd9, 5'd7);
      check("post_rst_x9", bus.rs1_data_o, BYP ? 32'h55 : 32'h0);
      check("post_rst_x7", bus.rs2_data_o, 32'h0);
      check("post_rst_cnt", bus.retire_cnt_o, 32'h0);
      clock_edge();
      drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd9);
      check("first_write_x9", bus.rs1_data_o, 32'h55);
      check("first_write_cnt", bus.retire_cnt_o, 32'h1);
      clock_edge();

      // Counter wrap via backdoor preload
      @(negedge clk);
      force u_dut.retire_cnt_q = 32'hFFFFFFFF;
      #1;
      release u_dut.retire_cnt_q;
      model_cnt = 32'hFFFFFFFF;
      check("preload_cnt", bus.retire_cnt_o, 32'hFFFFFFFF);
      drive(1'b0, 1'b1, 1'b1, 5'd12, 32'h0, 32'hCAFE0001, 5'd0, 5'd0);
      clock_edge();
      check("wrap_cnt", bus.retire_cnt_o, 32'h0);

      // Randomized traffic against the reference model
      for (int n = 0; n < 400; n++) begin
         r  = ($urandom_range(0, 49) == 0);
         we = ($urandom_range(0, 3) != 0);
         mr = 1'($urandom);
         rd = 5'($urandom);
         d1 = $urandom;
         d2 = $urandom;
         a1 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom);
         a2 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom);
         drive(r, we, mr, rd, d1, d2, a1, a2);
         check("rand_wbd", bus.wb_data_o, mr ? d2 : d1);
         check("rand_wbv", 32'(bus.wb_valid_o), 32'(we && rd != 5'd0));
         check("rand_rs1", bus.rs1_data_o, model_read(a1));
         check("rand_rs2", bus.rs2_data_o, model_read(a2));
         clock_edge();
         check("rand_cnt", bus.retire_cnt_o, model_cnt);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

`default_nettype wire
